// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants.
package fetch_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEF_PC_RESET = 32'h0000_3000;
  localparam logic [XLEN-1:0] DEF_NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_pkt_t;

  // Instruction fetches are always word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Single-outstanding instruction-memory request/ack bus.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush > stall > load > bubble.
module if_id_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INST = DEF_NOP_INST
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush_i,
  input  logic            stall_i,
  input  logic            load_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] inst_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] inst_o,
  output logic            valid_o
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inst_q;
  logic            valid_q;

  // Register update; a bubble or flush keeps the last PC for debug visibility.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q    <= '0;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else if (stall_i) begin
      pc_q    <= pc_q;
    end else if (load_i) begin
      pc_q    <= pc_i;
      inst_q  <= inst_i;
      valid_q <= 1'b1;
    end else begin
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end
  end

  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, imem handshake FSM, hold buffer, IF/ID register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_RESET = DEF_PC_RESET,
  parameter logic [XLEN-1:0] NOP_INST = DEF_NOP_INST
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             stall_pc,
  input  logic             stall_if_id,
  input  logic             flush_if_id,
  input  logic             npc_sel_ex,
  input  logic [XLEN-1:0]  npc_ex,
  fetch_unit_if.master     imem,
  output logic [XLEN-1:0]  pc_id,
  output logic [XLEN-1:0]  inst_id,
  output logic             valid_id
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  fetch_pkt_t      hold_q, hold_d;
  logic            req_q, req_d;

  logic            ifid_load_c;
  logic            ifid_hold_c;
  fetch_pkt_t      ifid_pkt_c;
  logic [XLEN-1:0] npc_c;

  // State, PC, redirect target, hold buffer and request flag.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      pc_f_q     <= PC_RESET;
      redir_pc_q <= '0;
      hold_q     <= '0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_f_q     <= pc_f_d;
      redir_pc_q <= redir_pc_d;
      hold_q     <= hold_d;
      req_q      <= req_d;
    end
  end

  // Next-state and IF/ID control; a redirect always wins over a PC stall.
  always_comb begin
    state_d         = state_q;
    pc_f_d          = pc_f_q;
    redir_pc_d      = redir_pc_q;
    hold_d          = hold_q;
    ifid_load_c     = 1'b0;
    ifid_hold_c     = 1'b0;
    ifid_pkt_c.pc   = pc_f_q;
    ifid_pkt_c.inst = imem.imem_rdata;
    npc_c           = word_align(npc_ex);

    unique case (state_q)
      IDLE: begin
        state_d = REQ;
      end
      REQ: begin
        if (imem.imem_ack) begin
          if (npc_sel_ex) begin
            pc_f_d = npc_c;
          end else if (stall_pc || stall_if_id) begin
            hold_d.pc   = pc_f_q;
            hold_d.inst = imem.imem_rdata;
            ifid_hold_c = 1'b1;
            state_d     = HOLD;
          end else begin
            ifid_load_c = 1'b1;
            pc_f_d      = pc_f_q + XLEN'(4);
          end
        end else if (npc_sel_ex) begin
          redir_pc_d = npc_c;
          state_d    = KILL;
        end
      end
      KILL: begin
        if (imem.imem_ack) begin
          pc_f_d  = npc_sel_ex ? npc_c : redir_pc_q;
          state_d = REQ;
        end else if (npc_sel_ex) begin
          redir_pc_d = npc_c;
        end
      end
      HOLD: begin
        if (npc_sel_ex) begin
          pc_f_d  = npc_c;
          state_d = REQ;
        end else if (!stall_pc && !stall_if_id) begin
          ifid_pkt_c  = hold_q;
          ifid_load_c = 1'b1;
          pc_f_d      = hold_q.pc + XLEN'(4);
          state_d     = REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    req_d = (state_d == REQ) || (state_d == KILL);
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_f_q;

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk     (clk),
    .rstn    (rstn),
    .flush_i (flush_if_id),
    .stall_i (stall_if_id | ifid_hold_c),
    .load_i  (ifid_load_c),
    .pc_i    (ifid_pkt_c.pc),
    .inst_i  (ifid_pkt_c.inst),
    .pc_o    (pc_id),
    .inst_o  (inst_id),
    .valid_o (valid_id)
  );

endmodule
